// File: rtl/usbhid_gamepad_events.sv
// usbhid_gamepad_events: HID report capture to button press/release events, with watchdog and optional auto-repeat (USBHID_AUTOREPEAT_EN)
module usbhid_gamepad_events #(
   parameter int C_report_bytes   = 20,
   parameter int C_btn_byte       = 2,
   parameter int C_delay_cycles   = 2400000,
   parameter int C_rate_cycles    = 600000,
   parameter int C_timeout_cycles = 1200000
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [C_report_bytes*8-1:0] hid_report,
   input  logic                        hid_valid,
   output logic [15:0]                 btn_state,
   output logic [15:0]                 btn_press,
   output logic [15:0]                 btn_release,
   output logic                        btn_event,
   output logic                        connected,
   output logic [7:0]                  report_count
);
   localparam int C_dr  = C_delay_cycles > C_rate_cycles ? C_delay_cycles : C_rate_cycles;
   localparam int C_max = C_dr > C_timeout_cycles ? C_dr : C_timeout_cycles;
   localparam int W     = $clog2(C_max);
   localparam logic [W-1:0] TO_LAST = W'(C_timeout_cycles - 1);
   logic            valid_q;
   logic [15:0]     btn_state_q, btn_state_d;
   logic [15:0]     btn_press_q, btn_press_d;
   logic [15:0]     btn_release_q, btn_release_d;
   logic            btn_event_q, connected_q, connected_d;
   logic [7:0]      report_count_q, report_count_d;
   logic [W-1:0]    to_q, to_d;
   logic            cap, to_exp, tick;
   logic [15:0]     new_btn, press_edge;
   logic            unused_bits;
   assign unused_bits = ^hid_report;
`ifdef USBHID_AUTOREPEAT_EN
   localparam logic [W-1:0] DLY_LAST  = W'(C_delay_cycles - 1);
   localparam logic [W-1:0] RATE_LAST = W'(C_rate_cycles - 1);
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_e;
   rpt_e         rpt_q;
   logic [W-1:0] rc_q;
   logic         rc_last;
   assign rc_last = rc_q == (rpt_q == DELAY ? DLY_LAST : RATE_LAST);
   assign tick    = rpt_q != IDLE && rc_last;
   // repeat scheduler: a press edge restarts the hold delay, an empty button set parks it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rpt_q <= IDLE;
         rc_q  <= '0;
      end else if (btn_state_d == '0) begin
         rpt_q <= IDLE;
         rc_q  <= '0;
      end else if (cap && press_edge != '0) begin
         rpt_q <= DELAY;
         rc_q  <= '0;
      end else if (rpt_q != IDLE) begin
         rpt_q <= rc_last ? REPEAT : rpt_q;
         rc_q  <= rc_last ? '0 : rc_q + W'(1);
      end
   end
`else
   assign tick = 1'b0;
`endif
   // next-state for capture, strobes and watchdog; a capture overrides a coincident tick or expiry
   always_comb begin
      cap            = hid_valid & ~valid_q;
      new_btn        = hid_report[C_btn_byte*8 +: 16];
      press_edge     = new_btn & ~btn_state_q;
      to_exp         = connected_q & ~cap & (to_q == TO_LAST);
      btn_state_d    = cap ? new_btn : to_exp ? '0 : btn_state_q;
      btn_press_d    = cap ? press_edge : (tick && !to_exp) ? btn_state_q : '0;
      btn_release_d  = cap ? btn_state_q & ~new_btn : to_exp ? btn_state_q : '0;
      connected_d    = cap | (connected_q & ~to_exp);
      report_count_d = report_count_q + 8'(cap);
      to_d           = (cap | ~connected_q | to_exp) ? '0 : to_q + W'(1);
   end
   // registered outputs and capture-edge history
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q        <= 1'b0;
         btn_state_q    <= '0;
         btn_press_q    <= '0;
         btn_release_q  <= '0;
         btn_event_q    <= 1'b0;
         connected_q    <= 1'b0;
         report_count_q <= '0;
         to_q           <= '0;
      end else begin
         valid_q        <= hid_valid;
         btn_state_q    <= btn_state_d;
         btn_press_q    <= btn_press_d;
         btn_release_q  <= btn_release_d;
         btn_event_q    <= |{btn_press_d, btn_release_d};
         connected_q    <= connected_d;
         report_count_q <= report_count_d;
         to_q           <= to_d;
      end
   end
   assign btn_state    = btn_state_q;
   assign btn_press    = btn_press_q;
   assign btn_release  = btn_release_q;
   assign btn_event    = btn_event_q;
   assign connected    = connected_q;
   assign report_count = report_count_q;
endmodule

// File: tb/tb_usbhid_gamepad_events.sv
// tb_usbhid_gamepad_events: directed and randomized checks against a schedule-based reference model
module tb_usbhid_gamepad_events;
   localparam int RB = 8, BB = 2, D = 20, R = 8, T = 50;
`ifdef USBHID_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   logic clk = 1'b0, resetn = 1'b0, hid_valid = 1'b0;
   logic [RB*8-1:0] hid_report = '0;
   logic [15:0] btn_state, btn_press, btn_release;
   logic btn_event, connected;
   logic [7:0] report_count;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   usbhid_gamepad_events #(
      .C_report_bytes(RB), .C_btn_byte(BB), .C_delay_cycles(D),
      .C_rate_cycles(R), .C_timeout_cycles(T)
   ) dut (
      .clk(clk), .resetn(resetn), .hid_report(hid_report), .hid_valid(hid_valid),
      .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
      .btn_event(btn_event), .connected(connected), .report_count(report_count)
   );
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask
   // reference model: button set, connection, and an absolute-time repeat schedule
   logic [15:0] m_st = '0, m_press = '0, m_rel = '0, nb, p;
   logic m_conn = 1'b0, m_vprev = 1'b0;
   logic [7:0] m_cnt = '0;
   int cyc = 0, last_cap = 0, next_rep = -1;
   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
         m_st = '0; m_press = '0; m_rel = '0; m_conn = 1'b0; m_vprev = 1'b0;
         m_cnt = '0; cyc = 0; last_cap = 0; next_rep = -1;
      end else begin
         cyc++;
         m_press = '0;
         m_rel = '0;
         if (hid_valid && !m_vprev) begin
            nb = hid_report[BB*8 +: 16];
            p = nb & ~m_st;
            m_press = p;
            m_rel = m_st & ~nb;
            m_st = nb;
            m_conn = 1'b1;
            m_cnt++;
            last_cap = cyc;
            if (AR) begin
               if (p != '0) next_rep = cyc + D;
               else if (m_st == '0) next_rep = -1;
               else if (next_rep == cyc) next_rep = cyc + R;
            end
         end else if (m_conn && cyc - last_cap == T) begin
            m_rel = m_st;
            m_st = '0;
            m_conn = 1'b0;
            next_rep = -1;
         end else if (AR && next_rep == cyc) begin
            m_press = m_st;
            next_rep = cyc + R;
         end
         m_vprev = hid_valid;
      end
   end
   // every-cycle comparison, sampled mid-period
   initial forever begin
      @(negedge clk);
      chk("state", btn_state, m_st);
      chk("press", btn_press, m_press);
      chk("release", btn_release, m_rel);
      chk("event", 16'(btn_event), 16'(|{m_press, m_rel}));
      chk("connected", 16'(connected), 16'(m_conn));
      chk("count", 16'(report_count), 16'(m_cnt));
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic put(input logic [15:0] b);
      hid_report = {$urandom, $urandom};
      hid_report[BB*8 +: 16] = b;
      hid_valid = 1'b1;
   endtask
   logic [15:0] mask;
   int rate;
   initial begin
      step(3);
      chk("rst_state", btn_state, 16'h0);
      chk("rst_conn", 16'(connected), 16'h0);
      chk("rst_count", 16'(report_count), 16'h0);
      resetn = 1'b1;
      step(2);
      put(16'h0005);
      step(1);
      chk("first_press", btn_press, 16'h0005);
      chk("first_state", btn_state, 16'h0005);
      chk("first_conn", 16'(connected), 16'h1);
      chk("first_count", 16'(report_count), 16'h1);
      chk("first_rel", btn_release, 16'h0);
      for (int i = 0; i < 10; i++) begin
         hid_report = {$urandom, $urandom};
         step(1);
      end
      chk("level_count", 16'(report_count), 16'h1);
      chk("level_state", btn_state, 16'h0005);
      hid_valid = 1'b0;
      step(1);
      put(16'h0104);
      step(1);
      chk("chg_press", btn_press, 16'h0100);
      chk("chg_rel", btn_release, 16'h0001);
      chk("chg_event", 16'(btn_event), 16'h1);
      hid_valid = 1'b0;
      step(1);
      chk("chg_event_off", 16'(btn_event), 16'h0);
      put(16'h0000);
      step(1);
      hid_valid = 1'b0;
      step(1);
      put(16'h0001);
      step(1);
      hid_valid = 1'b0;
      step(20);
      chk("rep20", btn_press, AR ? 16'h0001 : 16'h0);
      step(8);
      chk("rep28", btn_press, AR ? 16'h0001 : 16'h0);
      step(1);
      put(16'h0003);
      step(1);
      chk("newpress30", btn_press, 16'h0002);
      hid_valid = 1'b0;
      step(19);
      chk("norep49", btn_press, 16'h0);
      step(1);
      chk("rep50", btn_press, AR ? 16'h0003 : 16'h0);
      step(30);
      chk("to_rel", btn_release, 16'h0003);
      chk("to_conn", 16'(connected), 16'h0);
      put(16'h0081);
      step(1);
      hid_valid = 1'b0;
      step(48);
      put(16'h0081);
      step(1);
      chk("to_race_conn", 16'(connected), 16'h1);
      chk("to_race_rel", btn_release, 16'h0);
      hid_valid = 1'b0;
      step(50);
      chk("to81_rel", btn_release, 16'h0081);
      chk("to81_conn", 16'(connected), 16'h0);
      chk("to81_press", btn_press, 16'h0);
      put(16'h0001);
      step(1);
      hid_valid = 1'b0;
      step(25);
      resetn = 1'b0;
      #1;
      chk("arst_state", btn_state, 16'h0);
      chk("arst_press", btn_press, 16'h0);
      chk("arst_count", 16'(report_count), 16'h0);
      step(2);
      resetn = 1'b1;
      step(30);
      chk("post_rst_press", btn_press, 16'h0);
      for (int s = 0; s < 20; s++) begin
         mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
         rate = $urandom_range(1, 40);
         repeat (150) begin
            if ($urandom_range(0, rate) == 0) hid_valid = ~hid_valid;
            hid_report = {$urandom, $urandom};
            hid_report[BB*8 +: 16] = 16'($urandom) & mask;
            step(1);
         end
      end
      hid_valid = 1'b0;
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
